fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer_pkg.sv | 23 ++
 rtl/fifo_rd_packer_pacer.sv | 34 +++
 rtl/fifo_rd_packer.sv | 116 +++++++++++
 tb/tb_fifo_rd_packer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
//   pk_state_t : packer FSM state (FILL collects lanes, HOLD presents a word)
//   keep_mask  : low-ones mask with 'count' bits set, sized for the widest word
package fifo_rd_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_t;

  // Widest lane count the mask helper supports; callers slice to PACK bits.
  localparam int unsigned KEEP_MAX = 32;

  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned count);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_pacer.sv
// Read pacer: tracks idle cycles since the last FIFO pop so reads never
// come closer than the FIFO's own read-idle spacing.
//   rclk   : read-domain clock
//   rrst   : synchronous active-high reset
//   pop    : a pop is taken this cycle (clears the count)
//   pop_ok : enough idle cycles have elapsed for another pop
module rd_pacer #(
  parameter int READ_GAP = 4
) (
  input  logic rclk,
  input  logic rrst,
  input  logic pop,
  output logic pop_ok
);

  localparam int GW = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;

  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  // Saturating up-counter, restarted by every pop.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (pop)                             gap_cnt_d = '0;
    else if (gap_cnt_q != GW'(READ_GAP)) gap_cnt_d = gap_cnt_q + GW'(1);
  end

  always_ff @(posedge rclk) begin
    if (rrst) gap_cnt_q <= '0;
    else      gap_cnt_q <= gap_cnt_d;
  end

  assign pop_ok = (gap_cnt_q == GW'(READ_GAP));

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops bytes from the async FIFO read port at the
// FIFO's minimum read spacing, packs PACK lanes little-endian into one word
// and presents it on a valid/ready master with a lane-keep mask. 'flush'
// closes a partially filled word early.
//   rclk, rrst         : clock, synchronous active-high reset
//   rempty, rdata      : FIFO empty flag and head data
//   rinc               : FIFO read increment (one-cycle pulse per pop)
//   flush              : close the current partial word
//   m_data/m_keep      : packed word and lane-valid mask
//   m_valid/m_ready    : output handshake
//   busy               : partial word held or word pending
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int PACK     = 4,
  parameter int READ_GAP = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic [DSIZE*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int LW = $clog2(PACK);

  pk_state_t             state_q, state_d;
  logic [LW-1:0]         lane_idx_q, lane_idx_d;
  logic [DSIZE*PACK-1:0] data_q, data_d;
  logic [PACK-1:0]       keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  pop_ok, pop;
  int unsigned           fill_cnt;
  logic [KEEP_MAX-1:0]   mask_w;
  logic                  unused_mask;

  rd_pacer #(.READ_GAP(READ_GAP)) u_pacer (
    .rclk   (rclk),
    .rrst   (rrst),
    .pop    (pop),
    .pop_ok (pop_ok)
  );

  // Gated by reset so a FIFO byte is never consumed while the packer discards.
  assign pop  = (state_q == FILL) && pop_ok && !rempty && !rrst;
  assign rinc = pop;

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    data_d     = data_q;
    keep_d     = keep_q;
    valid_d    = valid_q;
    // Lanes filled once this cycle's pop (if any) lands.
    fill_cnt   = {{(32-LW){1'b0}}, lane_idx_q} + {31'b0, pop};
    mask_w     = keep_mask(fill_cnt);
    case (state_q)
      FILL: begin
        if (pop) begin
          for (int i = 0; i < PACK; i++) begin
            if (lane_idx_q == LW'(i)) data_d[i*DSIZE +: DSIZE] = rdata;
          end
          lane_idx_d = lane_idx_q + LW'(1);
        end
        // Full word, or flush with at least one lane (empty flush is dropped).
        if ((pop && lane_idx_q == LW'(PACK-1)) || (flush && fill_cnt != 0)) begin
          state_d    = HOLD;
          valid_d    = 1'b1;
          keep_d     = mask_w[PACK-1:0];
          lane_idx_d = '0;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d    = FILL;
          valid_d    = 1'b0;
          data_d     = '0;
          keep_d     = '0;
          lane_idx_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= FILL;
      lane_idx_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
    end
  end

  assign unused_mask = ^mask_w[KEEP_MAX-1:PACK];

  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_valid = valid_q;
  assign busy    = (state_q == HOLD) || (lane_idx_q != '0);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FIFO model.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  logic [7:0] q[$];
  int cyc;
  int errors;
  int checks;

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .READ_GAP(4)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  always #5 rclk = ~rclk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic upd();
    rempty = (q.size() == 0);
    rdata  = rempty ? 8'h00 : q[0];
  endtask

  // One clock: FIFO model pops if rinc was high, checks land at edge+2.
  task automatic tick();
    logic r;
    r = rinc;
    @(posedge rclk);
    #1;
    if (r && q.size() > 0) void'(q.pop_front());
    upd();
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input int n);
    if (n > 0) q.push_back(a);
    if (n > 1) q.push_back(b);
    if (n > 2) q.push_back(c);
    if (n > 3) q.push_back(d);
    upd();
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    q.delete();
    upd();
    tick();
    tick();
    rrst = 1'b0;
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rinc !== 1'b0)   begin errors++; $display("FAIL reset_rinc got=%b exp=0", rinc); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data); end
    checks++; if (m_keep !== 4'h0)  begin errors++; $display("FAIL reset_keep got=%b exp=0", m_keep); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fill();
    logic exp;
    do_reset();
    push4(8'h11, 8'h22, 8'h33, 8'h44, 4);
    for (int c = 0; c <= 20; c++) begin
      exp = (c == 4 || c == 9 || c == 14 || c == 19);
      checks++; if (rinc !== exp) begin errors++; $display("FAIL fill_rinc cyc=%0d got=%b exp=%b", c, rinc, exp); end
      if (c == 19) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid got=%b exp=0", m_valid); end
      end
      if (c < 20) tick();
    end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 32'h44332211) begin errors++; $display("FAIL fill_data got=%h exp=44332211", m_data); end
    checks++; if (m_keep !== 4'b1111) begin errors++; $display("FAIL fill_keep got=%b exp=1111", m_keep); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got=%b exp=1", busy); end
  endtask

  // Continues from HOLD left by test_fill.
  task automatic test_hold();
    int base;
    push4(8'h55, 8'h66, 8'h77, 8'h88, 4);
    for (int i = 0; i < 10; i++) begin
      checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL hold_rinc i=%0d got=%b exp=0", i, rinc); end
      checks++; if (m_data !== 32'h44332211 || m_valid !== 1'b1)
        begin errors++; $display("FAIL hold_stable i=%0d got=%h/%b exp=44332211/1", i, m_data, m_valid); end
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL accept_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 32'h0 || m_keep !== 4'h0)
      begin errors++; $display("FAIL accept_clear got=%h/%b exp=0/0", m_data, m_keep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy got=%b exp=0", busy); end
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL accept_next_pop got=%b exp=1", rinc); end
    base = cyc;
    run_to(base + 16);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h88776655)
      begin errors++; $display("FAIL b2b_word got=%b/%h exp=1/88776655", m_valid, m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_flush_partial();
    do_reset();
    push4(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
    run_to(12);
    checks++; if (busy !== 1'b1 || m_valid !== 1'b0 || rinc !== 1'b0)
      begin errors++; $display("FAIL partial_wait got=busy%b/vld%b/rinc%b exp=1/0/0", busy, m_valid, rinc); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got=%h exp=0000bbaa", m_data); end
    checks++; if (m_keep !== 4'b0011) begin errors++; $display("FAIL flush_keep got=%b exp=0011", m_keep); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL flush_accept got=%b/%b exp=0/0", m_valid, busy); end
  endtask

  task automatic test_flush_pop();
    do_reset();
    push4(8'hAA, 8'hBB, 8'hCC, 8'h00, 3);
    run_to(14);
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL third_pop got=%b exp=1", rinc); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (m_keep !== 4'b0111) begin errors++; $display("FAIL flushpop_keep got=%b exp=0111", m_keep); end
    checks++; if (m_data !== 32'h00CCBBAA) begin errors++; $display("FAIL flushpop_data got=%h exp=00ccbbaa", m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || rinc !== 1'b0)
        begin errors++; $display("FAIL empty_flush i=%0d got=vld%b/busy%b/rinc%b exp=0/0/0", i, m_valid, busy, rinc); end
    end
    flush = 1'b0;
  endtask

  task automatic test_rrst();
    do_reset();
    push4(8'h11, 8'h22, 8'h33, 8'h44, 4);
    run_to(21);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_pre got=%b exp=1", m_valid); end
    rrst = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0 || m_data !== 32'h0 || m_keep !== 4'h0 || busy !== 1'b0 || rinc !== 1'b0)
      begin errors++; $display("FAIL rst_hold got=%b/%h/%b/%b/%b exp=0/0/0/0/0", m_valid, m_data, m_keep, busy, rinc); end
    do_reset();
    push4(8'h01, 8'h02, 8'h03, 8'h00, 3);
    run_to(15);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_3lane_pre got=%b exp=1", busy); end
    rrst = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0 || m_data !== 32'h0 || m_keep !== 4'h0 || busy !== 1'b0 || rinc !== 1'b0)
      begin errors++; $display("FAIL rst_3lane got=%b/%h/%b/%b/%b exp=0/0/0/0/0", m_valid, m_data, m_keep, busy, rinc); end
    rrst = 1'b0;
    #1;
    cyc = 0;
    push4(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4);
    run_to(20);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hA4A3A2A1 || m_keep !== 4'b1111)
      begin errors++; $display("FAIL rst_fresh got=%b/%h/%b exp=1/a4a3a2a1/1111", m_valid, m_data, m_keep); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    test_reset();
    test_fill();
    test_hold();
    test_flush_partial();
    test_flush_pop();
    test_flush_empty();
    test_rrst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
